// File: rtl/el2_dec_gpr_wb_arb_if.sv
// el2_dec_gpr_wb_arb_if: writeback requester handshakes and the shared late GPR write port.
interface el2_dec_gpr_wb_arb_if #(
   parameter int NREQ = 3,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*5-1:0]  req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic               wen;
   logic [4:0]         waddr;
   logic [DW-1:0]      wd;
   modport master (output req_valid, req_addr, req_data, input req_ready, wen, waddr, wd);
   modport slave  (input req_valid, req_addr, req_data, output req_ready, wen, waddr, wd);
endinterface

// File: rtl/el2_dec_gpr_wb_arb.sv
// el2_dec_gpr_wb_arb: round-robin arbiter sharing one GPR write port among NREQ buffered sources.
// Optional pending-writeback scoreboard enabled by RV_GPR_WB_SCOREBOARD_EN.
module el2_dec_gpr_wb_arb #(
   parameter int NREQ = 3,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst_l,
   el2_dec_gpr_wb_arb_if.slave  wb,
   input  logic                 iss_valid,
   input  logic [4:0]           iss_addr,
   input  logic [4:0]           raddr0,
   input  logic [4:0]           raddr1,
   output logic                 hazard0,
   output logic                 hazard1,
   output logic [31:0]          busy,
   output logic                 sb_err
);
   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0] r_buf_v;
   logic [4:0]      r_buf_addr [NREQ];
   logic [DW-1:0]   r_buf_data [NREQ];
   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] w_gnt;
   logic [NREQ-1:0] w_acc;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_idx;
   logic            w_found;

   // First valid buffer at or after the pointer, wrapping.
   always_comb begin
      w_gnt   = '0;
      w_win   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = PW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && r_buf_v[w_idx]) begin
            w_found        = 1'b1;
            w_gnt[w_idx]   = 1'b1;
            w_win          = w_idx;
         end
      end
   end

   assign wb.wen       = |w_gnt;
   assign wb.waddr     = wb.wen ? r_buf_addr[w_win] : '0;
   assign wb.wd        = wb.wen ? r_buf_data[w_win] : '0;
   assign wb.req_ready = ~r_buf_v | w_gnt;
   assign w_acc        = wb.req_valid & wb.req_ready;

   // x0 writebacks are swallowed at accept; a reload beats the drain of the same buffer.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_buf_v <= '0;
         r_ptr   <= '0;
         for (int i = 0; i < NREQ; i++) begin
            r_buf_addr[i] <= '0;
            r_buf_data[i] <= '0;
         end
      end else begin
         if (wb.wen) r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (w_acc[i] && wb.req_addr[i*5 +: 5] != 5'd0) begin
               r_buf_v[i]    <= 1'b1;
               r_buf_addr[i] <= wb.req_addr[i*5 +: 5];
               r_buf_data[i] <= wb.req_data[i*DW +: DW];
            end else if (w_gnt[i]) begin
               r_buf_v[i] <= 1'b0;
            end
         end
      end
   end

`ifdef RV_GPR_WB_SCOREBOARD_EN
   logic [31:0] r_busy;
   logic        r_sb_err;
   logic [31:0] w_set;
   logic [31:0] w_clr;

   assign w_set = (iss_valid && iss_addr != 5'd0) ? (32'd1 << iss_addr) : '0;
   assign w_clr = wb.wen ? (32'd1 << wb.waddr) : '0;

   // Set wins over a same-cycle clear; bit 0 never marks pending.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_busy   <= '0;
         r_sb_err <= 1'b0;
      end else begin
         r_busy   <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
         r_sb_err <= |(w_set & r_busy & ~w_clr);
      end
   end

   assign busy    = r_busy;
   assign sb_err  = r_sb_err;
   assign hazard0 = r_busy[raddr0];
   assign hazard1 = r_busy[raddr1];
`else
   logic w_unused_sb;

   assign w_unused_sb = ^{iss_valid, iss_addr, raddr0, raddr1};
   assign busy        = '0;
   assign sb_err      = 1'b0;
   assign hazard0     = 1'b0;
   assign hazard1     = 1'b0;
`endif

endmodule

// File: tb/tb_el2_dec_gpr_wb_arb.sv
// tb_el2_dec_gpr_wb_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_el2_dec_gpr_wb_arb;
   localparam int NREQ = 3;
   localparam int DW   = 32;
`ifdef RV_GPR_WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_l = 1'b1;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  raddr0;
   logic [4:0]  raddr1;
   logic        hazard0;
   logic        hazard1;
   logic [31:0] busy;
   logic        sb_err;
   int          total = 0;
   int          bad = 0;

   el2_dec_gpr_wb_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

   el2_dec_gpr_wb_arb #(.NREQ(NREQ), .DW(DW)) dut (
      .clk(clk), .rst_l(rst_l), .wb(bus),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .raddr0(raddr0), .raddr1(raddr1),
      .hazard0(hazard0), .hazard1(hazard1), .busy(busy), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      iss_valid     = 1'b0;
      iss_addr      = '0;
      raddr0        = '0;
      raddr1        = '0;
   endtask

   task automatic put(input int i, input logic [4:0] a, input logic [31:0] d);
      bus.req_valid[i]         = 1'b1;
      bus.req_addr[i*5 +: 5]   = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      idle_inputs();
      #1 rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      raddr0 = 5'd5;
      raddr1 = 5'd7;
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      #2;
      total++;
      if ({bus.wen, bus.waddr, bus.wd} !== 38'd0) begin
         bad++; $display("FAIL reset_wport got=%b/%0d/%h want=0/0/0", bus.wen, bus.waddr, bus.wd);
      end
      total++;
      if (bus.req_ready !== 3'b111) begin
         bad++; $display("FAIL reset_ready got=%b want=111", bus.req_ready);
      end
      total++;
      if ({hazard0, hazard1, sb_err, busy} !== 35'd0) begin
         bad++; $display("FAIL reset_sb got=%b%b%b busy=%h want=000 busy=0", hazard0, hazard1, sb_err, busy);
      end
      @(negedge clk);
      rst_l = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      put(0, 5'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      total++;
      if ({bus.req_ready[0], bus.wen} !== 2'b10) begin
         bad++; $display("FAIL single_pre got rdy=%b wen=%b want rdy=1 wen=0", bus.req_ready[0], bus.wen);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({bus.wen, bus.waddr, bus.wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL single_wr got=%b/%0d/%h want=1/5/deadbeef", bus.wen, bus.waddr, bus.wd);
      end
      tick();
      @(negedge clk);
      total++;
      if (bus.wen !== 1'b0) begin
         bad++; $display("FAIL single_idle got wen=%b want 0", bus.wen);
      end
   endtask

   task automatic test_contention();
      logic [2:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NREQ; i++) put(i, 5'(i + 1), 32'h100 + i);
      tick();
      idle_inputs();
      for (int k = 0; k < NREQ; k++) begin
         @(negedge clk);
         exp_rdy = (k == 0) ? 3'b001 : (k == 1) ? 3'b011 : 3'b111;
         total++;
         if ({bus.wen, bus.waddr, bus.wd} !== {1'b1, 5'(k + 1), 32'h100 + k}) begin
            bad++; $display("FAIL contention_wr k=%0d got=%b/%0d/%h want=1/%0d/%h", k, bus.wen, bus.waddr, bus.wd, k + 1, 32'h100 + k);
         end
         total++;
         if (bus.req_ready !== exp_rdy) begin
            bad++; $display("FAIL contention_rdy k=%0d got=%b want=%b", k, bus.req_ready, exp_rdy);
         end
         tick();
      end
      @(negedge clk);
      total++;
      if (bus.wen !== 1'b0) begin
         bad++; $display("FAIL contention_idle got wen=%b want 0", bus.wen);
      end
   endtask

   task automatic test_streaming();
      logic [5:0] exp;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         put(0, 5'(7 + k), 32'hA0 + k);
         @(negedge clk);
         exp = (k > 0) ? {1'b1, 5'(6 + k)} : 6'd0;
         total++;
         if ({bus.req_ready[0], bus.wen, bus.waddr} !== {1'b1, exp}) begin
            bad++; $display("FAIL stream k=%0d got rdy=%b wen=%b addr=%0d want rdy=1 wen=%b addr=%0d", k, bus.req_ready[0], bus.wen, bus.waddr, exp[5], exp[4:0]);
         end
         tick();
      end
      idle_inputs();
      @(negedge clk);
      total++;
      if ({bus.wen, bus.waddr, bus.wd} !== {1'b1, 5'd9, 32'hA2}) begin
         bad++; $display("FAIL stream_last got=%b/%0d/%h want=1/9/a2", bus.wen, bus.waddr, bus.wd);
      end
      tick();
      @(negedge clk);
      total++;
      if (bus.wen !== 1'b0) begin
         bad++; $display("FAIL stream_idle got wen=%b want 0", bus.wen);
      end
   endtask

   task automatic test_x0_drop();
      logic [31:0] exp_busy;
      do_reset();
      iss_valid = 1'b1;
      iss_addr  = 5'd4;
      tick();
      iss_valid = 1'b0;
      put(1, 5'd0, 32'h1234);
      @(negedge clk);
      total++;
      if (bus.req_ready[1] !== 1'b1) begin
         bad++; $display("FAIL drop_rdy got=%b want=1", bus.req_ready[1]);
      end
      tick();
      idle_inputs();
      exp_busy = SB ? 32'h10 : 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if ({bus.wen, bus.req_ready, busy} !== {1'b0, 3'b111, exp_busy}) begin
            bad++; $display("FAIL drop_nowr k=%0d got wen=%b rdy=%b busy=%h want wen=0 rdy=111 busy=%h", k, bus.wen, bus.req_ready, busy, exp_busy);
         end
         tick();
      end
   endtask

   task automatic test_scoreboard();
      logic [31:0] b10;
      b10 = SB ? 32'h400 : 32'h0;
      do_reset();
      iss_valid = 1'b1;
      iss_addr  = 5'd10;
      tick();
      iss_valid = 1'b0;
      raddr0    = 5'd10;
      raddr1    = 5'd0;
      @(negedge clk);
      total++;
      if ({hazard0, hazard1, busy} !== {SB, 1'b0, b10}) begin
         bad++; $display("FAIL sb_set got hz=%b%b busy=%h want hz=%b0 busy=%h", hazard0, hazard1, busy, SB, b10);
      end
      put(2, 5'd10, 32'hCAFE);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      total++;
      if ({bus.wen, bus.waddr, hazard0} !== {1'b1, 5'd10, SB}) begin
         bad++; $display("FAIL sb_wr_cycle got wen=%b addr=%0d hz0=%b want 1/10/%b", bus.wen, bus.waddr, hazard0, SB);
      end
      tick();
      @(negedge clk);
      total++;
      if ({hazard0, busy} !== 33'd0) begin
         bad++; $display("FAIL sb_clear got hz0=%b busy=%h want 0/0", hazard0, busy);
      end
      iss_valid = 1'b1;
      iss_addr  = 5'd10;
      tick();
      tick();
      iss_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({sb_err, busy} !== {SB, b10}) begin
         bad++; $display("FAIL sb_err_pulse got err=%b busy=%h want err=%b busy=%h", sb_err, busy, SB, b10);
      end
      tick();
      @(negedge clk);
      total++;
      if (sb_err !== 1'b0) begin
         bad++; $display("FAIL sb_err_once got=%b want=0", sb_err);
      end
      put(0, 5'd10, 32'h55);
      tick();
      bus.req_valid = '0;
      iss_valid     = 1'b1;
      iss_addr      = 5'd10;
      raddr1        = 5'd10;
      @(negedge clk);
      total++;
      if ({bus.wen, bus.waddr} !== {1'b1, 5'd10}) begin
         bad++; $display("FAIL sb_setwins_wr got wen=%b addr=%0d want 1/10", bus.wen, bus.waddr);
      end
      tick();
      iss_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({sb_err, hazard1, busy} !== {1'b0, SB, b10}) begin
         bad++; $display("FAIL sb_setwins got err=%b hz1=%b busy=%h want 0/%b/%h", sb_err, hazard1, busy, SB, b10);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      iss_valid = 1'b1;
      iss_addr  = 5'd3;
      put(1, 5'd3, 32'h33);
      put(2, 5'd4, 32'h44);
      tick();
      idle_inputs();
      #1;
      total++;
      if ({bus.wen, bus.waddr} !== {1'b1, 5'd3}) begin
         bad++; $display("FAIL arst_pre got wen=%b addr=%0d want 1/3", bus.wen, bus.waddr);
      end
      #1 rst_l = 1'b0;
      #1;
      total++;
      if ({bus.wen, bus.waddr, bus.wd, bus.req_ready, busy} !== {38'd0, 3'b111, 32'd0}) begin
         bad++; $display("FAIL arst_now got wen=%b addr=%0d wd=%h rdy=%b busy=%h want 0/0/0/111/0", bus.wen, bus.waddr, bus.wd, bus.req_ready, busy);
      end
      @(negedge clk);
      #1 rst_l = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if ({bus.wen, busy} !== 33'd0) begin
            bad++; $display("FAIL arst_after k=%0d got wen=%b busy=%h want 0/0", k, bus.wen, busy);
         end
      end
      tick();
   endtask

   task automatic test_random();
      bit              mv [NREQ];
      logic [4:0]      ma [NREQ];
      logic [31:0]     md [NREQ];
      int              mptr;
      logic [31:0]     mbusy;
      bit              msb;
      int              best;
      int              bestd;
      int              d;
      logic            ew;
      logic [4:0]      ea;
      logic [31:0]     ed;
      logic [NREQ-1:0] er;
      logic            eh0;
      logic            eh1;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         mv[i] = 1'b0; ma[i] = '0; md[i] = '0;
      end
      mptr  = 0;
      mbusy = '0;
      msb   = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*5 +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
            bus.req_data[i*DW +: DW] = $urandom;
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_addr  = 5'($urandom_range(0, 9));
         raddr0    = 5'($urandom_range(0, 9));
         raddr1    = 5'($urandom_range(0, 9));
         @(negedge clk);
         best  = -1;
         bestd = NREQ;
         for (int j = 0; j < NREQ; j++) begin
            d = (j - mptr + NREQ) % NREQ;
            if (mv[j] && d < bestd) begin
               best  = j;
               bestd = d;
            end
         end
         ew = (best >= 0);
         ea = '0;
         ed = '0;
         if (best >= 0) begin
            ea = ma[best];
            ed = md[best];
         end
         for (int i = 0; i < NREQ; i++) er[i] = !mv[i] || (best == i);
         eh0 = (raddr0 != 0) && mbusy[raddr0];
         eh1 = (raddr1 != 0) && mbusy[raddr1];
         total++;
         if ({bus.wen, bus.waddr, bus.wd} !== {ew, ea, ed}) begin
            bad++; $display("FAIL rand_wport cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, bus.wen, bus.waddr, bus.wd, ew, ea, ed);
         end
         total++;
         if (bus.req_ready !== er) begin
            bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er);
         end
         total++;
         if ({hazard0, hazard1, sb_err, busy} !== {eh0, eh1, msb, mbusy}) begin
            bad++; $display("FAIL rand_sb cyc=%0d got hz=%b%b err=%b busy=%h want hz=%b%b err=%b busy=%h", cyc, hazard0, hazard1, sb_err, busy, eh0, eh1, msb, mbusy);
         end
         msb = SB && iss_valid && iss_addr != 0 && mbusy[iss_addr] && !(ew && ea == iss_addr);
         if (ew) mbusy[ea] = 1'b0;
         if (SB && iss_valid && iss_addr != 0) mbusy[iss_addr] = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && er[i] && bus.req_addr[i*5 +: 5] != 0) begin
               mv[i] = 1'b1;
               ma[i] = bus.req_addr[i*5 +: 5];
               md[i] = bus.req_data[i*DW +: DW];
            end else if (best == i) begin
               mv[i] = 1'b0;
            end
         end
         if (best >= 0) mptr = (best + 1) % NREQ;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_contention();
      test_streaming();
      test_x0_drop();
      test_scoreboard();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
